// File: rtl/adc_pingpong_buf_if.sv
// Write-stream, read-port and status bundle for the ping-pong ADC capture buffer.
// The master side feeds samples and read requests; the slave side is the buffer.
interface adc_pingpong_buf_if #(
    parameter int DWIDTH = 160,
    parameter int AWIDTH = 13
);
    logic              wvalid;
    logic              wsof;
    logic [DWIDTH-1:0] wdat;
    logic              ren;
    logic [AWIDTH-1:0] raddr;
    logic              rdone;
    logic              stat_clr;
    logic [DWIDTH-1:0] rdat;
    logic              rvalid;
    logic              rd_avail;
    logic              rd_bank;
    logic              wr_bank;
    logic              ovf;
    logic              runt;
    logic [15:0]       frame_cnt;

    modport master (
        output wvalid, wsof, wdat, ren, raddr, rdone, stat_clr,
        input  rdat, rvalid, rd_avail, rd_bank, wr_bank, ovf, runt, frame_cnt
    );

    modport slave (
        input  wvalid, wsof, wdat, ren, raddr, rdone, stat_clr,
        output rdat, rvalid, rd_avail, rd_bank, wr_bank, ovf, runt, frame_cnt
    );
endinterface

// File: rtl/adc_pingpong_buf.sv
// Two-bank ping-pong capture memory: the writer frames a sample stream into
// alternating banks, the reader random-reads one completed bank and releases it.
module adc_pingpong_buf #(
    parameter int DWIDTH    = 160,
    parameter int AWIDTH    = 13,
    parameter int FRAME_LEN = 8192,
    parameter int RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               rst,
    adc_pingpong_buf_if.slave  bus
);
    localparam int                DEPTH     = 2 ** (AWIDTH + 1);
    localparam logic [AWIDTH-1:0] LAST_WORD = AWIDTH'(FRAME_LEN - 1);

    typedef enum logic {W_SYNC, W_FILL} wstate_e;

    wstate_e           state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [AWIDTH-1:0] waddr_q, waddr_d;
    logic [1:0]        full_q, full_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              ovf_q, ovf_d;
    logic              runt_q, runt_d;
    logic [DWIDTH-1:0] rdat_q, rdat_d;
    logic              rvalid_q, rvalid_d;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic              wr_en;
    logic [AWIDTH-1:0] wr_word;
    logic              ovf_set, runt_set;
    logic              rd_avail, rd_release, rd_fire;
    logic [AWIDTH:0]   rd_idx;

    assign rd_avail   = full_q[rd_bank_q];
    assign rd_release = bus.rdone & rd_avail;
    assign rd_fire    = bus.ren & rd_avail;
    assign rd_idx     = {rd_bank_q, bus.raddr};

    always_comb begin : write_ctrl
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        waddr_d     = waddr_q;
        full_d      = full_q;
        frame_cnt_d = frame_cnt_q;
        wr_en       = 1'b0;
        wr_word     = waddr_q;
        ovf_set     = 1'b0;
        runt_set    = 1'b0;

        // The reader only ever clears the bank it owns, which the writer never touches.
        if (rd_release) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        case (state_q)
            W_SYNC: begin
                if (bus.wvalid) begin
                    if (full_q[wr_bank_q]) begin
                        ovf_set = 1'b1;
                    end else if (bus.wsof) begin
                        wr_en   = 1'b1;
                        wr_word = '0;
                        waddr_d = AWIDTH'(1);
                        state_d = W_FILL;
                    end
                end
            end
            W_FILL: begin
                if (bus.wvalid) begin
                    wr_en = 1'b1;
                    if (bus.wsof) begin
                        wr_word  = '0;
                        waddr_d  = AWIDTH'(1);
                        runt_set = (waddr_q != '0);
                    end else if (waddr_q == LAST_WORD) begin
                        full_d[wr_bank_q] = 1'b1;
                        waddr_d           = '0;
                        wr_bank_d         = ~wr_bank_q;
                        frame_cnt_d       = frame_cnt_q + 16'd1;
                        // A bank released this same cycle lets the stream continue unbroken.
                        if (full_d[~wr_bank_q]) state_d = W_SYNC;
                    end else begin
                        waddr_d = waddr_q + AWIDTH'(1);
                    end
                end
            end
            default: state_d = W_SYNC;
        endcase

        ovf_d  = (ovf_q  & ~bus.stat_clr) | ovf_set;
        runt_d = (runt_q & ~bus.stat_clr) | runt_set;
    end

    // NOTE: storage has no reset; a reset invalidates both banks through full_q instead.
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank_q, wr_word}] <= bus.wdat;
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s1_vld_q;
            logic [DWIDTH-1:0] s1_dat_q;

            always_ff @(posedge clk) begin
                if (rd_fire) s1_dat_q <= mem[rd_idx];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) s1_vld_q <= 1'b0;
                else     s1_vld_q <= rd_fire;
            end

            always_comb begin
                rvalid_d = s1_vld_q;
                rdat_d   = s1_vld_q ? s1_dat_q : rdat_q;
            end
        end else begin : g_lat1
            always_comb begin
                rvalid_d = rd_fire;
                rdat_d   = rd_fire ? mem[rd_idx] : rdat_q;
            end
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= W_SYNC;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            waddr_q     <= '0;
            full_q      <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            runt_q      <= 1'b0;
            rdat_q      <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            waddr_q     <= waddr_d;
            full_q      <= full_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
            runt_q      <= runt_d;
            rdat_q      <= rdat_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign bus.rdat      = rdat_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rd_avail  = rd_avail;
    assign bus.rd_bank   = rd_bank_q;
    assign bus.wr_bank   = wr_bank_q;
    assign bus.ovf       = ovf_q;
    assign bus.runt      = runt_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_adc_pingpong_buf.sv
// Directed bench: two buffers (read latency 1 and 2) share one stimulus stream,
// each scenario task compares outputs against hand-computed values.
module tb_adc_pingpong_buf;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int FL = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    adc_pingpong_buf_if #(.DWIDTH(DW), .AWIDTH(AW)) b1 ();
    adc_pingpong_buf_if #(.DWIDTH(DW), .AWIDTH(AW)) b2 ();

    assign b2.wvalid   = b1.wvalid;
    assign b2.wsof     = b1.wsof;
    assign b2.wdat     = b1.wdat;
    assign b2.ren      = b1.ren;
    assign b2.raddr    = b1.raddr;
    assign b2.rdone    = b1.rdone;
    assign b2.stat_clr = b1.stat_clr;

    adc_pingpong_buf #(.DWIDTH(DW), .AWIDTH(AW), .FRAME_LEN(FL), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );
    adc_pingpong_buf #(.DWIDTH(DW), .AWIDTH(AW), .FRAME_LEN(FL), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .bus(b2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b1.wvalid = 1'b0; b1.wsof = 1'b0; b1.wdat = '0;
        b1.ren = 1'b0; b1.raddr = '0; b1.rdone = 1'b0; b1.stat_clr = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic sof, input logic [DW-1:0] d);
        b1.wvalid = 1'b1; b1.wsof = sof; b1.wdat = d;
        step();
        b1.wvalid = 1'b0; b1.wsof = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        b1.ren = 1'b1; b1.raddr = a;
        step();
        b1.ren = 1'b0;
    endtask

    task automatic pulse_rdone();
        b1.rdone = 1'b1;
        step();
        b1.rdone = 1'b0;
    endtask

    task automatic pulse_stat_clr();
        b1.stat_clr = 1'b1;
        step();
        b1.stat_clr = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({b1.rdat, b1.rvalid, b1.rd_avail, b1.rd_bank, b1.wr_bank, b1.ovf, b1.runt, b1.frame_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_lat1: got %0h want 0", {b1.rdat, b1.rvalid, b1.rd_avail, b1.rd_bank, b1.wr_bank, b1.ovf, b1.runt, b1.frame_cnt});
        end
        checks++;
        if ({b2.rdat, b2.rvalid, b2.rd_avail, b2.rd_bank, b2.wr_bank, b2.ovf, b2.runt, b2.frame_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_lat2: got %0h want 0", {b2.rdat, b2.rvalid, b2.rd_avail, b2.rd_bank, b2.wr_bank, b2.ovf, b2.runt, b2.frame_cnt});
        end
    endtask

    task automatic test_basic_frame();
        apply_reset();
        push(1'b1, 16'd0);
        for (int i = 1; i < FL - 1; i++) push(1'b0, 16'(i));
        checks++;
        if ({b1.rd_avail, b1.frame_cnt} !== {1'b0, 16'd0}) begin
            failures++;
            $display("FAIL basic_before_last: got %0h want 0", {b1.rd_avail, b1.frame_cnt});
        end
        push(1'b0, 16'd15);
        checks++;
        if ({b1.rd_avail, b1.frame_cnt, b1.wr_bank, b1.rd_bank} !== {1'b1, 16'd1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL basic_complete: got %0h want %0h", {b1.rd_avail, b1.frame_cnt, b1.wr_bank, b1.rd_bank}, {1'b1, 16'd1, 1'b1, 1'b0});
        end
        for (int i = 0; i < FL; i++) begin
            rd(AW'(i));
            checks++;
            if ({b1.rvalid, b1.rdat} !== {1'b1, 16'(i)}) begin
                failures++;
                $display("FAIL basic_read[%0d]: got %0h want %0h", i, {b1.rvalid, b1.rdat}, {1'b1, 16'(i)});
            end
        end
        step();
        checks++;
        if ({b1.rvalid, b1.rdat} !== {1'b0, 16'd15}) begin
            failures++;
            $display("FAIL basic_hold: got %0h want %0h", {b1.rvalid, b1.rdat}, {1'b0, 16'd15});
        end
        pulse_rdone();
        checks++;
        if ({b1.rd_avail, b1.rd_bank} !== 2'b01) begin
            failures++;
            $display("FAIL basic_release: got %0b want 01", {b1.rd_avail, b1.rd_bank});
        end
        pulse_rdone();
        checks++;
        if ({b1.rd_avail, b1.rd_bank} !== 2'b01) begin
            failures++;
            $display("FAIL basic_idle_rdone: got %0b want 01", {b1.rd_avail, b1.rd_bank});
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_bank = 3'b010;
        int         f = 0;
        logic       rel;
        apply_reset();
        for (int t = 0; t < 56; t++) begin
            b1.wvalid = (t < 48); b1.wsof = (t == 0); b1.wdat = 16'(t);
            rel = b1.rd_avail;
            if (rel) begin
                checks++;
                if (b1.rd_bank !== exp_bank[f]) begin
                    failures++;
                    $display("FAIL stream_bank[%0d]: got %0b want %0b", f, b1.rd_bank, exp_bank[f]);
                end
            end
            b1.ren = rel; b1.rdone = rel; b1.raddr = 4'd3;
            step();
            if (rel) begin
                checks++;
                if ({b1.rvalid, b1.rdat} !== {1'b1, 16'(f * FL + 3)}) begin
                    failures++;
                    $display("FAIL stream_data[%0d]: got %0h want %0h", f, {b1.rvalid, b1.rdat}, {1'b1, 16'(f * FL + 3)});
                end
                f++;
            end
        end
        idle_inputs();
        checks++;
        if (f != 3) begin
            failures++;
            $display("FAIL stream_frames: got %0d want 3", f);
        end
        checks++;
        if ({b1.ovf, b1.frame_cnt} !== {1'b0, 16'd3}) begin
            failures++;
            $display("FAIL stream_status: got %0h want %0h", {b1.ovf, b1.frame_cnt}, {1'b0, 16'd3});
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int t = 0; t < 40; t++) push(t == 0, 16'(t));
        checks++;
        if ({b1.rd_avail, b1.rd_bank, b1.wr_bank, b1.ovf, b1.frame_cnt} !== {4'b1001, 16'd2}) begin
            failures++;
            $display("FAIL ovf_full: got %0h want %0h", {b1.rd_avail, b1.rd_bank, b1.wr_bank, b1.ovf, b1.frame_cnt}, {4'b1001, 16'd2});
        end
        pulse_rdone();
        checks++;
        if ({b1.rd_avail, b1.rd_bank} !== 2'b11) begin
            failures++;
            $display("FAIL ovf_release: got %0b want 11", {b1.rd_avail, b1.rd_bank});
        end
        rd(4'd0);
        checks++;
        if (b1.rdat !== 16'd16) begin
            failures++;
            $display("FAIL ovf_bank1_w0: got %0d want 16", b1.rdat);
        end
        rd(4'd15);
        checks++;
        if (b1.rdat !== 16'd31) begin
            failures++;
            $display("FAIL ovf_bank1_w15: got %0d want 31", b1.rdat);
        end
        pulse_stat_clr();
        for (int i = 0; i < 3; i++) push(1'b0, 16'(256 + i));
        checks++;
        if ({b1.ovf, b1.frame_cnt} !== {1'b0, 16'd2}) begin
            failures++;
            $display("FAIL ovf_silent_drop: got %0h want %0h", {b1.ovf, b1.frame_cnt}, {1'b0, 16'd2});
        end
        push(1'b1, 16'h55);
        for (int i = 1; i < FL; i++) push(1'b0, 16'(16'h55 + i));
        checks++;
        if ({b1.frame_cnt, b1.wr_bank} !== {16'd3, 1'b1}) begin
            failures++;
            $display("FAIL ovf_refill: got %0h want %0h", {b1.frame_cnt, b1.wr_bank}, {16'd3, 1'b1});
        end
        b1.stat_clr = 1'b1;
        push(1'b0, 16'h77);
        b1.stat_clr = 1'b0;
        checks++;
        if (b1.ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set_wins_clr: got %0b want 1", b1.ovf);
        end
        pulse_rdone();
        rd(4'd0);
        checks++;
        if ({b1.rd_bank, b1.rdat} !== {1'b0, 16'h55}) begin
            failures++;
            $display("FAIL ovf_bank0_w0: got %0h want %0h", {b1.rd_bank, b1.rdat}, {1'b0, 16'h55});
        end
        rd(4'd15);
        checks++;
        if (b1.rdat !== 16'h64) begin
            failures++;
            $display("FAIL ovf_bank0_w15: got %0h want 64", b1.rdat);
        end
    endtask

    task automatic test_runt();
        apply_reset();
        push(1'b1, 16'd0);
        for (int i = 1; i < 5; i++) push(1'b0, 16'(i));
        checks++;
        if (b1.runt !== 1'b0) begin
            failures++;
            $display("FAIL runt_early: got %0b want 0", b1.runt);
        end
        push(1'b1, 16'd100);
        checks++;
        if (b1.runt !== 1'b1) begin
            failures++;
            $display("FAIL runt_set: got %0b want 1", b1.runt);
        end
        for (int i = 1; i < FL - 1; i++) push(1'b0, 16'(100 + i));
        checks++;
        if ({b1.rd_avail, b1.frame_cnt} !== {1'b0, 16'd0}) begin
            failures++;
            $display("FAIL runt_not_done: got %0h want 0", {b1.rd_avail, b1.frame_cnt});
        end
        push(1'b0, 16'd115);
        checks++;
        if ({b1.rd_avail, b1.frame_cnt} !== {1'b1, 16'd1}) begin
            failures++;
            $display("FAIL runt_done: got %0h want %0h", {b1.rd_avail, b1.frame_cnt}, {1'b1, 16'd1});
        end
        rd(4'd0);
        checks++;
        if (b1.rdat !== 16'd100) begin
            failures++;
            $display("FAIL runt_w0: got %0d want 100", b1.rdat);
        end
        rd(4'd5);
        checks++;
        if (b1.rdat !== 16'd105) begin
            failures++;
            $display("FAIL runt_w5: got %0d want 105", b1.rdat);
        end
        pulse_stat_clr();
        checks++;
        if (b1.runt !== 1'b0) begin
            failures++;
            $display("FAIL runt_clr: got %0b want 0", b1.runt);
        end
    endtask

    task automatic test_rd_lat2();
        apply_reset();
        b1.ren = 1'b1; b1.raddr = 4'd1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) b1.ren = 1'b0;
            step();
            checks++;
            if ({b1.rvalid, b2.rvalid} !== 2'b00) begin
                failures++;
                $display("FAIL lat2_no_avail[%0d]: got %0b want 00", k, {b1.rvalid, b2.rvalid});
            end
        end
        push(1'b1, 16'h200);
        for (int i = 1; i < FL; i++) push(1'b0, 16'(16'h200 + i));
        for (int k = 0; k < 18; k++) begin
            logic        exp_v;
            logic [15:0] exp_d;
            b1.ren = (k < FL); b1.raddr = AW'(k);
            step();
            exp_v = (k >= 1) && (k <= FL);
            exp_d = (k == 0) ? 16'd0 : (k <= FL) ? 16'(16'h200 + k - 1) : 16'h20F;
            checks++;
            if ({b2.rvalid, b2.rdat} !== {exp_v, exp_d}) begin
                failures++;
                $display("FAIL lat2_beat[%0d]: got %0h want %0h", k, {b2.rvalid, b2.rdat}, {exp_v, exp_d});
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        push(1'b1, 16'h300);
        for (int i = 1; i < FL; i++) push(1'b0, 16'(16'h300 + i));
        push(1'b1, 16'h400);
        for (int i = 1; i < 5; i++) push(1'b0, 16'(16'h400 + i));
        b1.ren = 1'b1; b1.raddr = 4'd2;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({b1.rdat, b1.rvalid, b1.rd_avail, b1.rd_bank, b1.wr_bank, b1.ovf, b1.runt, b1.frame_cnt} !== '0) begin
            failures++;
            $display("FAIL mid_reset_lat1: got %0h want 0", {b1.rdat, b1.rvalid, b1.rd_avail, b1.rd_bank, b1.wr_bank, b1.ovf, b1.runt, b1.frame_cnt});
        end
        checks++;
        if ({b2.rdat, b2.rvalid, b2.rd_avail, b2.rd_bank, b2.wr_bank, b2.ovf, b2.runt, b2.frame_cnt} !== '0) begin
            failures++;
            $display("FAIL mid_reset_lat2: got %0h want 0", {b2.rdat, b2.rvalid, b2.rd_avail, b2.rd_bank, b2.wr_bank, b2.ovf, b2.runt, b2.frame_cnt});
        end
        step();
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 20; i++) push(1'b0, 16'(16'h450 + i));
        checks++;
        if ({b1.frame_cnt, b1.rd_avail, b1.ovf} !== '0) begin
            failures++;
            $display("FAIL mid_reset_needs_sof: got %0h want 0", {b1.frame_cnt, b1.rd_avail, b1.ovf});
        end
        push(1'b1, 16'h500);
        for (int i = 1; i < FL; i++) push(1'b0, 16'(16'h500 + i));
        rd(4'd0);
        checks++;
        if ({b1.frame_cnt, b1.rd_avail, b1.rdat} !== {16'd1, 1'b1, 16'h500}) begin
            failures++;
            $display("FAIL mid_reset_refill: got %0h want %0h", {b1.frame_cnt, b1.rd_avail, b1.rdat}, {16'd1, 1'b1, 16'h500});
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_overflow();
        test_runt();
        test_rd_lat2();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_pingpong_buf.md
# adc_pingpong_buf

Double-buffered (ping-pong) capture memory for ADC sample streams; generalised successor to the single-bank capture RAM. The write side accepts a continuous `wvalid` stream, self-addresses it into frames of `FRAME_LEN` words and alternates between two banks. The read side owns one completed bank at a time, random-reads it and releases it with `rdone`. Sits between the ADC packer and the matrix/DMA reader; reports overflow and short frames as sticky status.

## Interface
- `DWIDTH`, 160, sample word width
- `AWIDTH`, 13, address width per bank; bank depth = 2^AWIDTH
- `FRAME_LEN`, 8192, words per frame, 2..2^AWIDTH
- `RD_LAT`, 1, read latency 1 or 2 (2 adds an output register)

- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `wvalid`  in  1  sample strobe
- `wsof`  in  1  start of frame, qualified by `wvalid`
- `wdat`  in  DWIDTH  sample data
- `ren`  in  1  read request
- `raddr`  in  AWIDTH  word address within the read bank
- `rdone`  in  1  release current read bank (pulse)
- `stat_clr`  in  1  clears `ovf` and `runt`
- `rdat`  out  DWIDTH  read data
- `rvalid`  out  1  `rdat` valid
- `rd_avail`  out  1  a completed bank is owned by the reader
- `rd_bank`  out  1  bank presented to the reader
- `wr_bank`  out  1  bank being filled
- `ovf`  out  1  sticky: sample dropped because the write bank was full
- `runt`  out  1  sticky: `wsof` arrived mid-frame
- `frame_cnt`  out  16  completed frames, wraps 0xFFFF->0

## Operation
- Memory: 2*2^AWIDTH words, address {bank, word}. Per-bank `full` flag. Write pointer `waddr`.
- Reset: state W_SYNC; `wr_bank`=0, `rd_bank`=0, `waddr`=0, both `full`=0, `rdat`=0, `rvalid`=0, `rd_avail`=0, `ovf`=0, `runt`=0, `frame_cnt`=0. Reset mid-frame discards all buffered data.
- Accepted write: `mem[{wr_bank,waddr}]`<=`wdat`, `waddr`++.
- W_SYNC: `wvalid`&`wsof`&!`full[wr_bank]` -> write at word 0, `waddr`=1, go W_FILL. `wvalid` while `full[wr_bank]` -> drop, set `ovf`. `wvalid` without `wsof`, bank free -> drop silently.
- W_FILL: `wvalid` writes at `waddr`. `wsof` with `wvalid` -> sample written at word 0, `waddr`=1, set `runt`; partial frame discarded.
- Frame complete (write at `waddr`=FRAME_LEN-1): set `full[wr_bank]`, `waddr`=0, toggle `wr_bank`, `frame_cnt`++. If new `wr_bank` is free stay W_FILL (next sample continues the stream, `wsof` not required), else go W_SYNC.
- Reader: `rd_avail` = `full[rd_bank]`. `ren` while `rd_avail` reads `{rd_bank,raddr}`; `ren` while !`rd_avail` ignored (no `rvalid`). `raddr` >= FRAME_LEN returns stale bank contents, no error.
- `rdone` while `rd_avail`: clear `full[rd_bank]`, toggle `rd_bank`. `rdone` while !`rd_avail` ignored. Banks are consumed strictly in fill order.
- `stat_clr` clears both sticky bits; if a set event occurs the same cycle, the bit stays set.
- Simultaneous frame completion and `rdone`: both applied; writer and reader never act on the same bank's `full` in one cycle. Bank freed by `rdone` is writable the following cycle.

## Timing
- Write: memory and `full` update on the edge sampling the last word; `rd_avail` high the next cycle.
- `ren` same cycle as `rdone`: read uses the pre-toggle `rd_bank`.
- Read latency RD_LAT cycles: `rdat`/`rvalid` valid RD_LAT edges after `ren` sampled; one read per cycle, fully pipelined. `rvalid` low otherwise; `rdat` holds last value.
- Read of a word written earlier in the same frame is not possible (bank not yet owned by reader); no read/write collision exists.

## Test plan
- AWIDTH=4, FRAME_LEN=16, RD_LAT=1: wsof + 16 words 0..15 -> `rd_avail`=1 next cycle, `frame_cnt`=1, `wr_bank`=1; reads 0..15 return 0..15 one cycle later with `rvalid`.
- Continuous stream 48 words, reader releases each bank promptly -> three frames delivered in order banks 0,1,0; `ovf`=0.
- Reader never releases; 40 words streamed -> banks 0,1 full, 8 samples dropped, `ovf`=1; after `rdone`, words without `wsof` dropped silently, `wsof` word lands at bank 0 word 0.
- wsof at word 5 of a frame -> `runt`=1, frame restarts, completes after 16 more words; `stat_clr` -> `runt`=0.
- RD_LAT=2: back-to-back `ren` on 16 addresses -> 16 consecutive `rvalid` beats starting 2 cycles after first `ren`; `ren` with `rd_avail`=0 -> no `rvalid`.
- `rst` asserted mid-frame and during a read burst -> all outputs at reset values immediately; first frame after release requires `wsof`.
